// File: rtl/sample_pkt_pkg.sv
// rtl/sample_pkt_pkg.sv - shared constants, state encoding and helpers for the sample packetizer
package sample_pkt_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC0 = 3'd1,
    ST_SYNC1 = 3'd2,
    ST_SEQ   = 3'd3,
    ST_MSB   = 3'd4,
    ST_LSB   = 3'd5,
    ST_CSUM  = 3'd6
  } pkt_state_e;

  function automatic int pkt_len(input int n);
    return 4 + 2 * n;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through sample FIFO with one-entry lookahead
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_fast,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         dout_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign dout       = mem[rd_ptr];
  // Entry behind the head, so a consumer can register it on the same edge it pops.
  assign dout_next  = mem[rd_ptr_nxt];

  always_ff @(posedge clk_fast) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_packetizer.sv
// rtl/sample_packetizer.sv - frames 16-bit samples into sync/seq/payload/checksum byte packets
module sample_packetizer
  import sample_pkt_pkg::*;
#(
  parameter int SAMPLES_PER_PKT = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic        sample_ready_o,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        overflow_o,
  output logic [15:0] drop_count_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;
  localparam logic [LW-1:0] N_LVL    = LW'(SAMPLES_PER_PKT);
  localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLES_PER_PKT - 1);

  pkt_state_e      state;
  pkt_state_e      next_state;
  logic [7:0]      next_byte;
  logic [7:0]      seq;
  logic [7:0]      csum;
  logic [IW-1:0]   sample_idx;
  logic            hs;
  logic            push;
  logic            pop;
  logic            drop;
  logic            full;
  logic            empty;
  logic [LW-1:0]   level;
  logic [15:0]     fifo_dout;
  logic [15:0]     fifo_dout_next;
  logic [15:0]     head;

  assign push           = sample_valid_i && !full;
  assign drop           = sample_valid_i && full;
  assign sample_ready_o = !full;
  assign hs             = byte_valid_o && byte_ready_i;
  // Leaving LSB pops the head on the same edge, so the following MSB comes from the lookahead entry.
  assign head           = (state == ST_LSB) ? fifo_dout_next : fifo_dout;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_fast  (clk_i),
    .rst_n     (rstn_i),
    .push      (push),
    .pop       (pop),
    .din       (sample_i),
    .dout      (fifo_dout),
    .dout_next (fifo_dout_next),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_comb begin
    next_state = state;
    next_byte  = byte_o;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty && level >= N_LVL) begin
          next_state = ST_SYNC0;
          next_byte  = SYNC0;
        end
      end
      ST_SYNC0: begin
        if (hs) begin
          next_state = ST_SYNC1;
          next_byte  = SYNC1;
        end
      end
      ST_SYNC1: begin
        if (hs) begin
          next_state = ST_SEQ;
          next_byte  = seq;
        end
      end
      ST_SEQ: begin
        if (hs) begin
          next_state = ST_MSB;
          next_byte  = head[15:8];
        end
      end
      ST_MSB: begin
        if (hs) begin
          next_state = ST_LSB;
          next_byte  = head[7:0];
        end
      end
      ST_LSB: begin
        if (hs) begin
          pop = 1'b1;
          if (sample_idx == LAST_IDX) begin
            next_state = ST_CSUM;
            next_byte  = csum ^ byte_o;
          end else begin
            next_state = ST_MSB;
            next_byte  = head[15:8];
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          next_state = ST_IDLE;
          next_byte  = 8'h00;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_byte  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= ST_IDLE;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
    end else begin
      state        <= next_state;
      byte_o       <= next_byte;
      byte_valid_o <= (next_state != ST_IDLE);
    end
  end

  // Checksum folds in each SEQ/payload byte as it is accepted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq        <= 8'h00;
      csum       <= 8'h00;
      sample_idx <= '0;
    end else if (state == ST_IDLE) begin
      csum       <= 8'h00;
      sample_idx <= '0;
    end else if (hs) begin
      unique case (state)
        ST_SEQ, ST_MSB: csum <= csum ^ byte_o;
        ST_LSB: begin
          csum       <= csum ^ byte_o;
          sample_idx <= sample_idx + 1'b1;
        end
        ST_CSUM: seq <= seq + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= 16'h0000;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_count_o != 16'hFFFF) begin
        drop_count_o <= drop_count_o + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_sample_packetizer.sv
// tb/tb_sample_packetizer.sv - directed self-checking bench for sample_packetizer
module tb_sample_packetizer;
  import sample_pkt_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 16;
  localparam int PLEN  = pkt_len(N);

  logic        clk;
  logic        rstn;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] wr      [0:63];
  logic [7:0]  exp_pkt [0:63];
  logic [7:0]  got     [0:63];
  int          got_cyc [0:63];
  int          got_n;
  int          hold_changes;
  logic [7:0]  hold_byte;

  sample_packetizer #(
    .SAMPLES_PER_PKT (N),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .sample_ready_o (sample_ready),
    .byte_o         (byte_data),
    .byte_valid_o   (byte_valid),
    .byte_ready_i   (byte_ready),
    .overflow_o     (overflow),
    .drop_count_o   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void build_pkt(input logic [7:0] seq, input int first);
    logic [7:0] c;
    c = seq;
    exp_pkt[0] = 8'hA5;
    exp_pkt[1] = 8'h5A;
    exp_pkt[2] = seq;
    for (int k = 0; k < N; k++) begin
      exp_pkt[3 + 2 * k] = wr[first + k][15:8];
      exp_pkt[4 + 2 * k] = wr[first + k][7:0];
      c = c ^ wr[first + k][15:8] ^ wr[first + k][7:0];
    end
    exp_pkt[PLEN - 1] = c;
  endfunction

  task automatic apply_reset();
    rstn         = 1'b0;
    sample_valid = 1'b0;
    byte_ready   = 1'b0;
    sample       = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_words(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      sample       = wr[first + i];
      sample_valid = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
  endtask

  task automatic collect(input int nbytes, input int stall_at, input int stall_len);
    int left;
    bit stalling;
    got_n        = 0;
    hold_changes = 0;
    hold_byte    = 8'h00;
    left         = stall_len;
    stalling     = 1'b0;
    for (int i = 0; i < 64; i++) got[i] = 'x;
    for (int cyc = 0; cyc < 3000 && got_n < nbytes; cyc++) begin
      if (left > 0 && (stalling || (got_n == stall_at && byte_valid))) begin
        if (!stalling) hold_byte = byte_data;
        else if (byte_data !== hold_byte || byte_valid !== 1'b1) hold_changes++;
        stalling   = 1'b1;
        left--;
        byte_ready = 1'b0;
      end else begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          got[got_n]     = byte_data;
          got_cyc[got_n] = cyc;
          got_n++;
        end
      end
      @(negedge clk);
    end
    byte_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn         = 1'b0;
    sample_valid = 1'b0;
    byte_ready   = 1'b0;
    sample       = 16'h0000;
    @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0 || byte_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte valid=%b byte=%02h expected valid=0 byte=00", byte_valid, byte_data);
    end
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_drop overflow=%b drops=%0d expected 0 0", overflow, drop_count);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (sample_ready !== 1'b1 || byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready=%b valid=%b expected ready=1 valid=0", sample_ready, byte_valid);
    end
  endtask

  task automatic test_basic();
    int bad;
    apply_reset();
    for (int k = 0; k < N; k++) wr[k] = 16'(k + 1);
    push_words(0, N);
    collect(PLEN, -1, 0);
    build_pkt(8'h00, 0);
    checks++;
    if (got_n !== PLEN) begin
      errors++;
      $display("FAIL basic_count got %0d bytes expected %0d", got_n, PLEN);
    end
    bad = -1;
    for (int i = 0; i < PLEN; i++) if (bad < 0 && got[i] !== exp_pkt[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL basic_pkt byte %0d got %02h expected %02h", bad, got[bad], exp_pkt[bad]);
    end
    checks++;
    if (got[PLEN - 1] !== 8'h08) begin
      errors++;
      $display("FAIL basic_csum got %02h expected 08", got[PLEN - 1]);
    end
    checks++;
    if (got_cyc[PLEN - 1] - got_cyc[0] !== PLEN - 1) begin
      errors++;
      $display("FAIL basic_span got %0d cycles expected %0d", got_cyc[PLEN - 1] - got_cyc[0], PLEN - 1);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    apply_reset();
    for (int k = 0; k < N; k++) wr[k] = 16'(k + 1);
    push_words(0, N);
    collect(PLEN, 7, 5);
    build_pkt(8'h00, 0);
    bad = -1;
    for (int i = 0; i < PLEN; i++) if (bad < 0 && got[i] !== exp_pkt[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL bp_pkt byte %0d got %02h expected %02h", bad, got[bad], exp_pkt[bad]);
    end
    checks++;
    if (hold_byte !== 8'h00 || hold_changes !== 0) begin
      errors++;
      $display("FAIL bp_hold byte=%02h changes=%0d expected 00 0", hold_byte, hold_changes);
    end
    checks++;
    if (got_cyc[PLEN - 1] - got_cyc[0] !== PLEN - 1 + 5) begin
      errors++;
      $display("FAIL bp_span got %0d expected %0d", got_cyc[PLEN - 1] - got_cyc[0], PLEN + 4);
    end
  endtask

  task automatic test_overflow();
    int bad;
    logic r15;
    logic r16;
    apply_reset();
    r15 = 1'b0;
    r16 = 1'b1;
    for (int i = 0; i < 20; i++) wr[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) r15 = sample_ready;
      if (i == 16) r16 = sample_ready;
      sample       = wr[i];
      sample_valid = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    checks++;
    if (r15 !== 1'b1 || r16 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ready at15=%b at16=%b expected 1 0", r15, r16);
    end
    checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd4) begin
      errors++;
      $display("FAIL ovf_flags overflow=%b drops=%0d expected 1 4", overflow, drop_count);
    end
    collect(2 * PLEN, -1, 0);
    build_pkt(8'h00, 0);
    bad = -1;
    for (int i = 0; i < PLEN; i++) if (bad < 0 && got[i] !== exp_pkt[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL ovf_pkt0 byte %0d got %02h expected %02h", bad, got[bad], exp_pkt[bad]);
    end
    build_pkt(8'h01, 8);
    bad = -1;
    for (int i = 0; i < PLEN; i++) if (bad < 0 && got[PLEN + i] !== exp_pkt[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL ovf_pkt1 byte %0d got %02h expected %02h", bad, got[PLEN + bad], exp_pkt[bad]);
    end
    checks++;
    if (got_cyc[PLEN] - got_cyc[PLEN - 1] !== 2) begin
      errors++;
      $display("FAIL ovf_gap got %0d expected 2", got_cyc[PLEN] - got_cyc[PLEN - 1]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained valid=%b ready=%b expected 0 1", byte_valid, sample_ready);
    end
  endtask

  task automatic test_seq_wrap();
    int bad;
    apply_reset();
    for (int p = 0; p < 257; p++) begin
      for (int k = 0; k < N; k++) wr[k] = 16'(p * 37 + k * 4099 + 1);
      push_words(0, N);
      collect(PLEN, -1, 0);
      build_pkt(8'(p), 0);
      checks++;
      if (got[2] !== 8'(p)) begin
        errors++;
        $display("FAIL wrap_seq pkt %0d got %02h expected %02h", p, got[2], 8'(p));
      end
      bad = -1;
      for (int i = 0; i < PLEN; i++) if (bad < 0 && got[i] !== exp_pkt[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL wrap_pkt pkt %0d byte %0d got %02h expected %02h", p, bad, got[bad], exp_pkt[bad]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    apply_reset();
    for (int k = 0; k < N; k++) wr[k] = 16'h0300 + 16'(k * 17);
    push_words(0, N);
    collect(PLEN - 1, -1, 0);
    build_pkt(8'h00, 0);
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== exp_pkt[PLEN - 1]) begin
      errors++;
      $display("FAIL mid_csum valid=%b byte=%02h expected 1 %02h", byte_valid, byte_data, exp_pkt[PLEN - 1]);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (byte_valid !== 1'b0 || byte_data !== 8'h00 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async valid=%b byte=%02h ready=%b expected 0 00 1", byte_valid, byte_data, sample_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) wr[k] = 16'h0400 + 16'(k);
    push_words(0, N);
    collect(PLEN, -1, 0);
    checks++;
    if (got[0] !== 8'hA5 || got[1] !== 8'h5A || got[2] !== 8'h00) begin
      errors++;
      $display("FAIL mid_restart got %02h %02h %02h expected a5 5a 00", got[0], got[1], got[2]);
    end
    build_pkt(8'h00, 0);
    bad = -1;
    for (int i = 0; i < PLEN; i++) if (bad < 0 && got[i] !== exp_pkt[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL mid_pkt byte %0d got %02h expected %02h", bad, got[bad], exp_pkt[bad]);
    end
  endtask

  task automatic test_push_pop_full();
    int bad;
    apply_reset();
    for (int i = 0; i < 16; i++) wr[i] = 16'h2000 + 16'(i);
    push_words(0, 16);
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL ppf_full ready=%b expected 0", sample_ready);
    end
    collect(4, -1, 0);
    sample       = 16'hBEEF;
    sample_valid = 1'b1;
    byte_ready   = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    byte_ready   = 1'b0;
    checks++;
    if (drop_count !== 16'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ppf_drop drops=%0d overflow=%b expected 1 1", drop_count, overflow);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL ppf_ready ready=%b expected 1", sample_ready);
    end
    collect(PLEN - 5, -1, 0);
    build_pkt(8'h00, 0);
    bad = -1;
    for (int i = 0; i < PLEN - 5; i++) if (bad < 0 && got[i] !== exp_pkt[5 + i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL ppf_pkt0 byte %0d got %02h expected %02h", bad + 5, got[bad], exp_pkt[5 + bad]);
    end
    collect(PLEN, -1, 0);
    build_pkt(8'h01, 8);
    bad = -1;
    for (int i = 0; i < PLEN; i++) if (bad < 0 && got[i] !== exp_pkt[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL ppf_pkt1 byte %0d got %02h expected %02h", bad, got[bad], exp_pkt[bad]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0) begin
      errors++;
      $display("FAIL ppf_empty valid=%b expected 0", byte_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_seq_wrap();
    test_reset_mid();
    test_push_pop_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
